// File: rtl/velocidad_medidor_pkg.sv
// Shared constants and FSM encoding for the velocity meter.
package velocidad_medidor_pkg;
  localparam int          DEF_WIDTH       = 24;
  localparam int unsigned DEF_GATE_CYCLES = 1000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LATCH = 2'd2
  } state_t;
endpackage

// File: rtl/velocidad_medidor_sincronizador_flanco.sv
// Brings the raw sensor pulse into the clock domain and flags its rising edges.
module sincronizador_flanco (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic flanco
);
  // sync[0], sync[1] form the metastability chain; sync[2] is the edge-detect delay.
  logic [2:0] sync;

  always_ff @(posedge clock) begin
    if (reset) sync <= '0;
    else       sync <= {sync[1:0], din};
  end

  assign flanco = sync[1] & ~sync[2];
endmodule

// File: rtl/velocidad_medidor.sv
// Gated pulse counter: counts sensor rising edges over GATE_CYCLES clocks and reports each window.
module velocidad_medidor
  import velocidad_medidor_pkg::*;
#(
  parameter int          WIDTH       = DEF_WIDTH,
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulseIn,
  output logic [WIDTH-1:0] velocidad,
  output logic             valid,
  output logic             overflow
);
  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 32'd1);

  state_t            state, state_nxt;
  logic [31:0]       gate_cnt;
  logic [WIDTH-1:0]  pcnt, pcnt_nxt;
  logic              ovf, ovf_nxt;
  logic              flanco;
  logic              last;

  sincronizador_flanco u_sync (
    .clock  (clock),
    .reset  (reset),
    .din    (pulseIn),
    .flanco (flanco)
  );

  assign last = (gate_cnt == GATE_LAST);

  // Saturating count: an edge at full scale only raises ovf.
  always_comb begin
    pcnt_nxt = pcnt;
    ovf_nxt  = ovf;
    if (flanco) begin
      if (&pcnt) ovf_nxt  = 1'b1;
      else       pcnt_nxt = pcnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    case (state)
      IDLE:    if (enable) state_nxt = COUNT;
      COUNT: begin
        if (!enable)   state_nxt = IDLE;
        else if (last) state_nxt = LATCH;
      end
      LATCH: begin
        valid     = 1'b1;
        state_nxt = enable ? COUNT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gate_cnt  <= '0;
      pcnt      <= '0;
      ovf       <= 1'b0;
      velocidad <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        COUNT: begin
          gate_cnt <= gate_cnt + 32'd1;
          pcnt     <= pcnt_nxt;
          ovf      <= ovf_nxt;
          // Results are loaded on entry to LATCH so they are on the outputs while valid is high.
          if (enable && last) begin
            velocidad <= pcnt_nxt;
            overflow  <= ovf_nxt;
          end
        end
        LATCH: begin
          gate_cnt <= '0;
          ovf      <= 1'b0;
          pcnt     <= WIDTH'(flanco);
        end
        default: begin
          gate_cnt <= '0;
          pcnt     <= '0;
          ovf      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_velocidad_medidor.sv
// Scoreboard bench: a window-level edge-count model feeds expected reports to a monitor.
module tb_velocidad_medidor;
  localparam int G = 100;

  logic        clock = 1'b0;
  logic        reset, enable, pulseIn;
  logic [23:0] vel;
  logic        valid, ovfl;
  logic [3:0]  vel4;
  logic        valid4, ovfl4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  velocidad_medidor #(.WIDTH(24), .GATE_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .enable(enable), .pulseIn(pulseIn),
    .velocidad(vel), .valid(valid), .overflow(ovfl)
  );

  velocidad_medidor #(.WIDTH(4), .GATE_CYCLES(G)) dut4 (
    .clock(clock), .reset(reset), .enable(enable), .pulseIn(pulseIn),
    .velocidad(vel4), .valid(valid4), .overflow(ovfl4)
  );

  typedef struct {
    longint v24;
    bit     o24;
    longint v4;
    bit     o4;
  } exp_t;
  exp_t q[$];

  // Reference state: mode 0 idle, 1 counting, 2 reporting; cnt is an unbounded edge count.
  int     mode = 0;
  int     pos = 0;
  longint cnt = 0;
  bit     h1 = 0, h2 = 0, h3 = 0;
  longint cur_v24 = 0, cur_v4 = 0;
  bit     cur_o24 = 0, cur_o4 = 0;

  function automatic longint satv(longint c, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A pulse level sampled at edge t is seen as a counted edge at edge t+2.
  always @(posedge clock) begin : model
    bit e;
    if (reset) begin
      mode = 0; pos = 0; cnt = 0;
      cur_v24 = 0; cur_v4 = 0; cur_o24 = 0; cur_o4 = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      e = h2 & ~h3;
      case (mode)
        0: if (enable) begin mode = 1; pos = 0; cnt = 0; end
        1: begin
          if (!enable) mode = 0;
          else begin
            cnt += longint'(e);
            if (pos == G - 1) begin
              exp_t x;
              x.v24 = satv(cnt, 24); x.o24 = cnt > satv(cnt, 24);
              x.v4  = satv(cnt, 4);  x.o4  = cnt > satv(cnt, 4);
              cur_v24 = x.v24; cur_o24 = x.o24; cur_v4 = x.v4; cur_o4 = x.o4;
              q.push_back(x);
              mode = 2;
            end else pos++;
          end
        end
        default: begin
          cnt  = longint'(e);
          pos  = 0;
          mode = enable ? 1 : 0;
        end
      endcase
      h3 = h2; h2 = h1; h1 = pulseIn;
    end
  end

  always @(negedge clock) begin : monitor
    exp_t x;
    chk("valid", valid, mode == 2);
    chk("valid4", valid4, mode == 2);
    chk("velocidad_hold", vel, cur_v24);
    chk("overflow_hold", ovfl, cur_o24);
    chk("velocidad4_hold", vel4, cur_v4);
    chk("overflow4_hold", ovfl4, cur_o4);
    if (valid === 1'b1) begin
      if (q.size() == 0) chk("sb_unexpected_valid", 1, 0);
      else begin
        x = q.pop_front();
        chk("sb_velocidad", vel, x.v24);
        chk("sb_overflow", ovfl, x.o24);
        chk("sb_velocidad4", vel4, x.v4);
        chk("sb_overflow4", ovfl4, x.o4);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulses(int n, int hi, int lo);
    repeat (n) begin
      pulseIn = 1'b1; cyc(hi);
      pulseIn = 1'b0; cyc(lo);
    end
  endtask

  task automatic wait_pos(int m, int p, string tag);
    int k;
    k = 0;
    while (!(mode == m && pos == p) && k < 500) begin
      @(negedge clock);
      k++;
    end
    if (k >= 500) begin
      n_chk++; n_fail++;
      $display("FAIL wait_%s: timeout waiting for mode %0d pos %0d", tag, m, p);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pulseIn = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(5);

    // Ten 4/4 pulses inside one window, then empty windows.
    enable = 1'b1;
    wait_pos(1, 0, "count");
    pulses(10, 4, 4);
    cyc(320);

    // 20 pulses saturate the 4-bit instance; next window of 3 clears overflow.
    wait_pos(1, 0, "sat");
    pulses(20, 2, 2);
    wait_pos(1, 0, "sat2");
    pulses(3, 2, 2);

    // Abort halfway through a window after a 10-pulse report.
    wait_pos(1, 0, "abort");
    pulses(10, 4, 4);
    wait_pos(1, 50, "abort_mid");
    enable = 1'b0;
    cyc(150);
    chk("abort_velocidad", vel, 10);

    // Edge landing on the last gate count, then an edge in the report cycle.
    enable = 1'b1;
    wait_pos(1, 97, "b99");
    pulseIn = 1'b1; cyc(2); pulseIn = 1'b0;
    wait_pos(2, 99, "b99_rep");
    chk("edge_at_99", vel, 1);
    wait_pos(1, 98, "blatch");
    pulseIn = 1'b1; cyc(2); pulseIn = 1'b0;
    cyc(1);
    wait_pos(2, 99, "blatch_rep");
    chk("edge_in_latch", vel, 1);

    // Reset mid-window with the pulse held high across release.
    wait_pos(1, 50, "rst");
    pulseIn = 1'b1;
    reset = 1'b1;
    cyc(1);
    chk("rst_velocidad", vel, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overflow", ovfl, 0);
    reset = 1'b0;
    cyc(5);
    pulseIn = 1'b0;
    cyc(150);

    // Random traffic.
    repeat (4000) begin
      cyc(1);
      pulseIn = 1'($urandom_range(0, 1));
      if (enable) begin
        if ($urandom_range(0, 399) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 9) == 0) enable = 1'b1;
      reset = ($urandom_range(0, 1499) == 0);
    end

    reset = 1'b0; enable = 1'b0; pulseIn = 1'b0;
    cyc(5);
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
